// File: rtl/mor1kx_spr_initiator_pkg.sv
// Shared constants for the SPR bus initiator: 2-bit FSM encoding and SPR address field helpers.
package mor1kx_spr_initiator_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int SPR_GROUP_MSB  = 15;
  localparam int SPR_GROUP_LSB  = 11;
  localparam int SPR_OFFSET_MSB = 10;

  function automatic logic [4:0] spr_group(input logic [15:0] addr);
    return addr[SPR_GROUP_MSB:SPR_GROUP_LSB];
  endfunction

  function automatic logic [10:0] spr_offset(input logic [15:0] addr);
    return addr[SPR_OFFSET_MSB:0];
  endfunction

endpackage

// File: rtl/mor1kx_spr_initiator.sv
// Runs single valid/ready SPR requests on the mor1kx SPR bus, returning data or a timeout error.
// Accept->access next cycle, response the cycle after ack; holds the response until rsp_ready_i.
module mor1kx_spr_initiator
  import mor1kx_spr_initiator_pkg::*;
#(
  parameter int OPTION_SPR_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  localparam int            CW         = (OPTION_SPR_TIMEOUT < 1) ? 1 : $clog2(OPTION_SPR_TIMEOUT + 1);
  localparam bit            TIMEOUT_EN = (OPTION_SPR_TIMEOUT != 0);
  localparam logic [CW-1:0] TMO        = CW'(OPTION_SPR_TIMEOUT);

  logic [1:0]    state_q;
  logic          rdy_en_q;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [31:0]   dat_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rsp_dat_q;
  logic          rsp_err_q;
  logic          in_access;

  assign in_access = (state_q == ST_ACCESS);

  // rdy_en_q keeps req_ready_o low until the first edge after reset release.
  assign req_ready_o  = rdy_en_q && (state_q == ST_IDLE);
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign spr_access_o = in_access;
  assign spr_we_o     = in_access && we_q;
  assign spr_addr_o   = in_access ? addr_q : 16'h0;
  assign spr_dat_o    = in_access ? dat_q : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_en_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 16'h0;
      dat_q     <= 32'h0;
      cnt_q     <= '0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            dat_q   <= req_we_i ? req_dat_i : 32'h0;
            cnt_q   <= CW'(1);
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Ack takes priority, so an ack in the last permitted cycle is a success.
          if (spr_bus_ack_i) begin
            rsp_dat_q <= we_q ? 32'h0 : spr_dat_i;
            rsp_err_q <= 1'b0;
            state_q   <= ST_RESP;
          end else if (TIMEOUT_EN && (cnt_q == TMO)) begin
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b1;
            state_q   <= ST_RESP;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_spr_initiator.sv
// Directed bench for mor1kx_spr_initiator with OPTION_SPR_TIMEOUT = 4 and a bench-driven responder.
module tb_mor1kx_spr_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        spr_access, spr_we, ack;
  logic [15:0] spr_addr;
  logic [31:0] spr_dat_o, sdat;

  int n_cmp = 0;
  int n_bad = 0;
  int acc;

  always #5 clk = ~clk;

  mor1kx_spr_initiator #(.OPTION_SPR_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_dat_i    (req_dat),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_err_o    (rsp_err),
    .spr_access_o (spr_access),
    .spr_we_o     (spr_we),
    .spr_addr_o   (spr_addr),
    .spr_dat_o    (spr_dat_o),
    .spr_bus_ack_i(ack),
    .spr_dat_i    (sdat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one request from IDLE, answers with ack in access cycle ack_at (0 = never),
  // returns the number of cycles spr_access_o was high. Ends in the first cycle after access.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                           input int ack_at, input logic [31:0] rdat, output int n_acc);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_dat = wdat;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!spr_access) break;
      n_acc++;
      chk("spr_we", {31'b0, spr_we}, {31'b0, we});
      chk("spr_addr", {16'b0, spr_addr}, {16'b0, addr});
      chk("spr_dat", spr_dat_o, we ? wdat : 32'h0);
      if (n_acc == ack_at) begin ack = 1'b1; sdat = rdat; end
      step();
      ack = 1'b0; sdat = 32'h0;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_dat = 32'h0;
    rsp_ready = 1'b0; ack = 1'b0; sdat = 32'h0;
    step(); step();
    chk("rst_spr_access", {31'b0, spr_access}, 32'd0);
    chk("rst_spr_addr", {16'b0, spr_addr}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Read PICMR, same-cycle ack
    do_access(1'b0, 16'h4800, 32'hFFFF_FFFF, 1, 32'h0000_0003, acc);
    chk("rd_acc_cycles", acc, 32'd1);
    chk("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rd_rsp_dat", rsp_dat, 32'h3);
    chk("rd_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rd_req_ready_resp", {31'b0, req_ready}, 32'd0);
    finish_rsp();

    // Write, same-cycle ack; responder data must be ignored
    do_access(1'b1, 16'h4802, 32'h0000_0005, 1, 32'h1234_5678, acc);
    chk("wr_acc_cycles", acc, 32'd1);
    chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("wr_rsp_dat", rsp_dat, 32'h0);
    chk("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    finish_rsp();

    // No ack: timeout after exactly 4 access cycles
    do_access(1'b0, 16'h0010, 32'h0, 0, 32'h0, acc);
    chk("to_acc_cycles", acc, 32'd4);
    chk("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    chk("to_rsp_dat", rsp_dat, 32'h0);
    finish_rsp();

    // Ack in the final permitted cycle wins
    do_access(1'b0, 16'h0010, 32'h0, 4, 32'hDEAD_BEEF, acc);
    chk("last_acc_cycles", acc, 32'd4);
    chk("last_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("last_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("last_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    finish_rsp();

    // Ack delayed two cycles: access high for three cycles
    do_access(1'b1, 16'h2801, 32'hCAFE_0001, 3, 32'h0, acc);
    chk("dly_acc_cycles", acc, 32'd3);
    chk("dly_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("dly_rsp_dat", rsp_dat, 32'h0);
    finish_rsp();

    // Response backpressure with a second request already offered
    do_access(1'b0, 16'h4801, 32'h0, 1, 32'hA5A5_0001, acc);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4802; req_dat = 32'h0000_0077;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_dat", rsp_dat, 32'hA5A5_0001);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_spr_access", {31'b0, spr_access}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_idle_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_idle_access", {31'b0, spr_access}, 32'd0);
    step();
    req_valid = 1'b0;
    chk("bp2_spr_access", {31'b0, spr_access}, 32'd1);
    chk("bp2_spr_we", {31'b0, spr_we}, 32'd1);
    chk("bp2_spr_dat", spr_dat_o, 32'h0000_0077);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("bp2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp2_rsp_dat", rsp_dat, 32'h0);
    finish_rsp();

    // Reset during the second access cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
    step();
    req_valid = 1'b0;
    chk("rm_access_c1", {31'b0, spr_access}, 32'd1);
    step();
    chk("rm_access_c2", {31'b0, spr_access}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_access_rst", {31'b0, spr_access}, 32'd0);
    chk("rm_rsp_valid_rst", {31'b0, rsp_valid}, 32'd0);
    chk("rm_req_ready_rst", {31'b0, req_ready}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rm_req_ready_rel", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rm_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("rm_no_access", {31'b0, spr_access}, 32'd0);
      step();
    end

    // Spurious acks in IDLE
    ack = 1'b1; sdat = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sp_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("sp_idle_access", {31'b0, spr_access}, 32'd0);
      chk("sp_idle_req_ready", {31'b0, req_ready}, 32'd1);
    end
    ack = 1'b0; sdat = 32'h0;

    // Spurious acks in RESP
    do_access(1'b0, 16'h4800, 32'h0, 1, 32'h0000_0011, acc);
    ack = 1'b1; sdat = 32'h0000_0022;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sp_resp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("sp_resp_dat", rsp_dat, 32'h0000_0011);
      chk("sp_resp_access", {31'b0, spr_access}, 32'd0);
    end
    ack = 1'b0; sdat = 32'h0;
    finish_rsp();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("sp_end_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
